// File: rtl/dma_steal_arb_pkg.sv
// Shared types for the DMA cycle-steal arbiter: FSM states, requester codes
// and the round-robin winner selection.
package dma_steal_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SEL_IDMA = 1'b0,
    SEL_BDMA = 1'b1
  } dma_sel_t;

  // Wide enough for a deferral limit of up to 15 cycles.
  localparam int DEFER_W = 4;

  // A lone requester always wins; on a tie the one not served last wins.
  function automatic dma_sel_t rr_pick(input logic ds, input logic bs,
                                       input dma_sel_t last);
    if (ds && bs) return (last == SEL_BDMA) ? SEL_IDMA : SEL_BDMA;
    else if (ds)  return SEL_IDMA;
    else          return SEL_BDMA;
  endfunction

endpackage

// File: rtl/dma_wait_cnt.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module dma_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/dma_steal_arb.sv
// Cycle-steal arbiter between IDMA and BDMA: requests a stolen slot from the
// core sequencer, grants one requester, and returns a one-cycle acknowledge.
module dma_steal_arb
  import dma_steal_arb_pkg::*;
#(
  parameter int MAX_DEFER = 8,
  parameter int WCNT_W    = 3
) (
  input  logic              DSPCLK,
  input  logic              T_RSTn,
  input  logic              DSreq,
  input  logic              BSreq,
  input  logic [WCNT_W-1:0] BDMA_wait,
  input  logic              STEAL_ok,
  input  logic              STBY,
  output logic              STEAL,
  output logic              STEAL_hard,
  output logic              DSreqx,
  output logic              BSreqx,
  output logic              DSack,
  output logic              BSack,
  output logic              arb_busy
);

  arb_state_t         r_state;
  dma_sel_t           r_sel;
  dma_sel_t           r_last_grant;
  logic [DEFER_W-1:0] r_defer_cnt;

  logic              w_ok;
  logic              w_load;
  logic              w_wcnt_zero;
  logic [WCNT_W-1:0] w_load_val;

  assign w_ok       = STEAL_ok | STBY;
  assign w_load     = (r_state == ST_REQ) && w_ok;
  assign w_load_val = (r_sel == SEL_BDMA) ? BDMA_wait : '0;

  dma_wait_cnt #(.W(WCNT_W)) u_wait_cnt (
    .clk        (DSPCLK),
    .rst_n      (T_RSTn),
    .i_load     (w_load),
    .i_dec      (r_state == ST_XFER),
    .i_load_val (w_load_val),
    .o_zero     (w_wcnt_zero)
  );

  // Reset leaves last_grant at BDMA so IDMA wins the first tie.
  always_ff @(posedge DSPCLK or negedge T_RSTn) begin
    if (!T_RSTn) begin
      r_state      <= ST_IDLE;
      r_sel        <= SEL_IDMA;
      r_last_grant <= SEL_BDMA;
      r_defer_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (DSreq || BSreq) begin
            r_sel   <= rr_pick(DSreq, BSreq, r_last_grant);
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ok) begin
            r_defer_cnt <= '0;
            r_state     <= ST_XFER;
          end else if (r_defer_cnt != DEFER_W'(MAX_DEFER)) begin
            r_defer_cnt <= r_defer_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (w_wcnt_zero) r_state <= ST_ACK;
        end
        ST_ACK: begin
          // Requests are ignored here; the IDMA drops DSreq late off DSack.
          r_last_grant <= r_sel;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state/sel flops, so they are glitch-free
  // and clear the instant reset is asserted.
  assign STEAL      = (r_state == ST_REQ) || (r_state == ST_XFER);
  assign STEAL_hard = (r_state == ST_REQ) && (r_defer_cnt == DEFER_W'(MAX_DEFER));
  assign DSreqx     = ((r_state == ST_XFER) || (r_state == ST_ACK)) && (r_sel == SEL_IDMA);
  assign BSreqx     = ((r_state == ST_XFER) || (r_state == ST_ACK)) && (r_sel == SEL_BDMA);
  assign DSack      = (r_state == ST_ACK) && (r_sel == SEL_IDMA);
  assign BSack      = (r_state == ST_ACK) && (r_sel == SEL_BDMA);
  assign arb_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dma_steal_arb.sv
// Directed bench for dma_steal_arb: inputs change and outputs are sampled on
// the falling clock edge, expectations are hand-derived cycle counts.
module tb_dma_steal_arb;

  logic       DSPCLK = 1'b0;
  logic       T_RSTn;
  logic       DSreq, BSreq, STEAL_ok, STBY;
  logic [2:0] BDMA_wait;
  logic       STEAL, STEAL_hard, DSreqx, BSreqx, DSack, BSack, arb_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 DSPCLK = ~DSPCLK;

  dma_steal_arb #(.MAX_DEFER(8), .WCNT_W(3)) dut (
    .DSPCLK     (DSPCLK),
    .T_RSTn     (T_RSTn),
    .DSreq      (DSreq),
    .BSreq      (BSreq),
    .BDMA_wait  (BDMA_wait),
    .STEAL_ok   (STEAL_ok),
    .STBY       (STBY),
    .STEAL      (STEAL),
    .STEAL_hard (STEAL_hard),
    .DSreqx     (DSreqx),
    .BSreqx     (BSreqx),
    .DSack      (DSack),
    .BSack      (BSack),
    .arb_busy   (arb_busy)
  );

  function automatic logic [6:0] outs();
    return {STEAL, STEAL_hard, DSreqx, BSreqx, DSack, BSack, arb_busy};
  endfunction

  // Steps falling edges until the selected ack is seen or the budget runs out.
  task automatic wait_ack(input bit is_bdma, input int budget,
                          output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge DSPCLK);
      cycles++;
      got = is_bdma ? BSack : DSack;
    end
  endtask

  task automatic do_reset();
    T_RSTn = 1'b0;
    repeat (2) @(negedge DSPCLK);
    T_RSTn = 1'b1;
    @(negedge DSPCLK);
  endtask

  task automatic test_reset();
    DSreq = 0; BSreq = 0; STEAL_ok = 1; STBY = 0; BDMA_wait = 3'd0;
    T_RSTn = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0000000", outs());
    end
    do_reset();
    n_cmp++;
    if (outs() !== 7'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b expected 0000000", outs());
    end
  endtask

  task automatic test_idma_single();
    DSreq = 1;
    @(negedge DSPCLK);
    n_cmp++;
    if ({STEAL, DSreqx, DSack} !== 3'b100) begin
      n_bad++;
      $display("FAIL idma_req_cycle: STEAL/DSreqx/DSack=%b expected 100", {STEAL, DSreqx, DSack});
    end
    @(negedge DSPCLK);
    n_cmp++;
    if ({STEAL, DSreqx, BSreqx, DSack} !== 4'b1100) begin
      n_bad++;
      $display("FAIL idma_xfer_cycle: STEAL/DSreqx/BSreqx/DSack=%b expected 1100", {STEAL, DSreqx, BSreqx, DSack});
    end
    @(negedge DSPCLK);
    n_cmp++;
    if ({STEAL, DSreqx, BSreqx, DSack, BSack} !== 5'b01010) begin
      n_bad++;
      $display("FAIL idma_ack_cycle: STEAL/DSreqx/BSreqx/DSack/BSack=%b expected 01010", {STEAL, DSreqx, BSreqx, DSack, BSack});
    end
    DSreq = 0;
    @(negedge DSPCLK);
    n_cmp++;
    if ({arb_busy, DSack, DSreqx} !== 3'b000) begin
      n_bad++;
      $display("FAIL idma_done: busy/DSack/DSreqx=%b expected 000", {arb_busy, DSack, DSreqx});
    end
  endtask

  task automatic test_bdma_wait();
    int  xfer_cycles = 0;
    int  n;
    bit  got = 1'b0;
    bit  ds_seen = 1'b0;
    BSreq = 1; BDMA_wait = 3'd3;
    for (n = 0; n < 20 && !got; n++) begin
      @(negedge DSPCLK);
      if (BSreqx && !BSack) begin
        xfer_cycles++;
        BDMA_wait = 3'd0;
      end
      if (DSreqx || DSack) ds_seen = 1'b1;
      got = BSack;
    end
    BSreq = 0;
    n_cmp++;
    if (!got || n != 6) begin
      n_bad++;
      $display("FAIL bdma_ack_latency: got=%0b after %0d cycles expected ack at 6", got, n);
    end
    n_cmp++;
    if (xfer_cycles != 4) begin
      n_bad++;
      $display("FAIL bdma_xfer_len: got %0d cycles expected 4", xfer_cycles);
    end
    n_cmp++;
    if (ds_seen) begin
      n_bad++;
      $display("FAIL bdma_no_idma_grant: got DSreqx/DSack high expected low");
    end
    @(negedge DSPCLK);
    n_cmp++;
    if ({arb_busy, BSack, BSreqx} !== 3'b000) begin
      n_bad++;
      $display("FAIL bdma_done: busy/BSack/BSreqx=%b expected 000", {arb_busy, BSack, BSreqx});
    end
  endtask

  task automatic test_round_robin();
    int  cyc;
    bit  got;
    do_reset();
    BDMA_wait = 3'd0;
    DSreq = 1; BSreq = 1;
    wait_ack(1'b0, 10, cyc, got);
    n_cmp++;
    if (!got || cyc != 3 || BSack !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_first_idma: got=%0b cycles=%0d BSack=%b expected DSack at 3, BSack 0", got, cyc, BSack);
    end
    DSreq = 0;
    repeat (3) @(negedge DSPCLK);
    n_cmp++;
    if ({BSreqx, DSreqx} !== 2'b10) begin
      n_bad++;
      $display("FAIL rr_bdma_next: BSreqx/DSreqx=%b expected 10", {BSreqx, DSreqx});
    end
    wait_ack(1'b1, 10, cyc, got);
    n_cmp++;
    if (!got || cyc != 1) begin
      n_bad++;
      $display("FAIL rr_bdma_ack: got=%0b cycles=%0d expected BSack at 1", got, cyc);
    end
    BSreq = 0;
    @(negedge DSPCLK);
    DSreq = 1; BSreq = 1;
    wait_ack(1'b0, 10, cyc, got);
    n_cmp++;
    if (!got || cyc != 3) begin
      n_bad++;
      $display("FAIL rr_idma_again: got=%0b cycles=%0d expected DSack at 3", got, cyc);
    end
    DSreq = 0;
    wait_ack(1'b1, 10, cyc, got);
    BSreq = 0;
    @(negedge DSPCLK);
  endtask

  task automatic test_defer();
    int  cyc;
    bit  got;
    DSreq = 1; STEAL_ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge DSPCLK);
      n_cmp++;
      if ({STEAL, STEAL_hard, DSreqx} !== {1'b1, (k >= 8), 1'b0}) begin
        n_bad++;
        $display("FAIL defer_k%0d: STEAL/STEAL_hard/DSreqx=%b expected %b", k,
                 {STEAL, STEAL_hard, DSreqx}, {1'b1, (k >= 8), 1'b0});
      end
    end
    STEAL_ok = 1;
    @(negedge DSPCLK);
    n_cmp++;
    if ({DSreqx, STEAL_hard} !== 2'b10) begin
      n_bad++;
      $display("FAIL defer_grant: DSreqx/STEAL_hard=%b expected 10", {DSreqx, STEAL_hard});
    end
    wait_ack(1'b0, 5, cyc, got);
    n_cmp++;
    if (!got || cyc != 1) begin
      n_bad++;
      $display("FAIL defer_ack: got=%0b cycles=%0d expected DSack at 1", got, cyc);
    end
    DSreq = 0;
    @(negedge DSPCLK);
  endtask

  task automatic test_reset_mid_xfer();
    int  cyc;
    bit  got;
    BSreq = 1; BDMA_wait = 3'd5;
    repeat (3) @(negedge DSPCLK);
    n_cmp++;
    if (BSreqx !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_xfer: BSreqx=%b expected 1", BSreqx);
    end
    T_RSTn = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_mid_xfer: got %b expected 0000000", outs());
    end
    @(negedge DSPCLK);
    n_cmp++;
    if (outs() !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_held: got %b expected 0000000", outs());
    end
    T_RSTn = 1'b1;
    wait_ack(1'b1, 15, cyc, got);
    n_cmp++;
    if (!got || cyc != 8) begin
      n_bad++;
      $display("FAIL rst_rearb: got=%0b cycles=%0d expected BSack at 8", got, cyc);
    end
    BSreq = 0;
    @(negedge DSPCLK);
  endtask

  task automatic test_stby();
    int  n;
    bit  got = 1'b0;
    BDMA_wait = 3'd0; STEAL_ok = 0; STBY = 1; BSreq = 1;
    for (n = 0; n < 10 && !got; n++) begin
      @(negedge DSPCLK);
      n_cmp++;
      if ((DSreqx && BSreqx) || (DSack && BSack) || STEAL_hard) begin
        n_bad++;
        $display("FAIL stby_invariant: DSreqx/BSreqx/DSack/BSack/STEAL_hard=%b expected one-hot, no hard",
                 {DSreqx, BSreqx, DSack, BSack, STEAL_hard});
      end
      got = BSack;
    end
    n_cmp++;
    if (!got || n != 3) begin
      n_bad++;
      $display("FAIL stby_ack: got=%0b after %0d cycles expected BSack at 3", got, n);
    end
    BSreq = 0; STBY = 0; STEAL_ok = 1;
    @(negedge DSPCLK);
  endtask

  initial begin
    test_reset();
    test_idma_single();
    test_bdma_wait();
    test_round_robin();
    test_defer();
    test_reset_mid_xfer();
    test_stby();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
